ldpc_gather_forest: RTL and testbench

Read-side counterpart to the LDPC write-side mux forest: accepts one 8-lane read request (per lane: branch, RAM index, offset), issues reads into the 8×NUM_RAMS RAM bank array, and re-assembles the returned words into 8 output lanes. When lanes collide on the same (branch, RAM), the block serialises them over multiple issue rounds. It feeds the LDPC check/variable node processors from the message RAMs.

---
 rtl/ldpc_gather_pkg.sv | 30 +++
 rtl/ldpc_gather_round_arbiter.sv | 29 ++
 rtl/ldpc_gather_forest.sv | 156 +++++++++++++++
 tb/tb_ldpc_gather_forest.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_gather_pkg.sv
// Shared types and constants for the LDPC read-side gather forest.
// LDPC_GATHER_OFFSET_SHARE_EN: same (branch, RAM, offset) lanes share one read.
package ldpc_gather_pkg;

    localparam int LANES    = 8;
    localparam int BRANCHES = 8;
    localparam int BR_W     = 3;
    localparam int RAM_IW   = 8;
    localparam int OFF_W    = 16;

`ifdef LDPC_GATHER_OFFSET_SHARE_EN
    localparam bit OFFSET_SHARE = 1'b1;
`else
    localparam bit OFFSET_SHARE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [BR_W-1:0]   branch;
        logic [RAM_IW-1:0] ram;
        logic [OFF_W-1:0]  offset;
    } lane_req_t;

endpackage

// File: rtl/ldpc_gather_round_arbiter.sv
// One issue round: grants each pending lane not blocked by a lower pending lane
// on the same (branch, RAM). Offset sharing follows LDPC_GATHER_OFFSET_SHARE_EN.
module ldpc_gather_round_arbiter
    import ldpc_gather_pkg::*;
(
    input  logic [LANES-1:0] i_pending,
    input  lane_req_t        i_req [LANES],
    output logic [LANES-1:0] o_grant
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic w_blocked;
            always_comb begin
                w_blocked = 1'b0;
                for (int m = 0; m < gi; m++) begin
                    if (i_pending[m]
                        && (i_req[m].branch == i_req[gi].branch)
                        && (i_req[m].ram == i_req[gi].ram)
                        && (!OFFSET_SHARE || (i_req[m].offset != i_req[gi].offset))) begin
                        w_blocked = 1'b1;
                    end
                end
            end
            assign o_grant[gi] = i_pending[gi] && !w_blocked;
        end
    endgenerate

endmodule

// File: rtl/ldpc_gather_forest.sv
// Read-side gather forest: issues 8-lane reads into the branch x RAM bank and
// reassembles returned words per lane. Build option: LDPC_GATHER_OFFSET_SHARE_EN.
module ldpc_gather_forest
    import ldpc_gather_pkg::*;
#(
    parameter int  WIDTH            = 8,
    parameter int  NUM_RAMS         = 24,
    parameter int  EXPANSION_FACTOR = 96,
    parameter int  RAM_LATENCY      = 2,
    localparam int AW               = $clog2(EXPANSION_FACTOR),
    localparam int RW               = $clog2(NUM_RAMS),
    localparam int NR               = BRANCHES * NUM_RAMS,
    localparam int TW               = $clog2(NR)
)(
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [LANES-1:0]       i_lane_valid,
    input  logic [LANES*AW-1:0]    i_offset,
    input  logic [LANES*RW-1:0]    i_ram_addr,
    input  logic [LANES*BR_W-1:0]  i_from_branch,
    output logic [NR-1:0]          o_rd_en,
    output logic [NR*AW-1:0]       o_rd_addr,
    input  logic [NR*WIDTH-1:0]    i_rd_data,
    output logic                   o_valid,
    output logic [LANES-1:0]       o_lane_valid,
    output logic [LANES*WIDTH-1:0] o_data,
    output logic                   o_error
);

    state_t                 r_state, w_state_next;
    logic [LANES-1:0]       r_pending, r_accepted;
    logic [LANES-1:0]       w_grant, w_issue, w_in_range;
    logic                   w_accept;
    lane_req_t              r_req [LANES];
    logic [TW-1:0]          r_tgt [LANES];
    logic [WIDTH-1:0]       r_hold [LANES];
    logic                   r_error;
    logic [LANES*WIDTH-1:0] w_cap;

    // Delay line mirrors the RAM read latency so each round's grants meet their data.
    logic [RAM_LATENCY-1:0] r_dly_valid;
    logic [LANES-1:0]       r_dly_grant [RAM_LATENCY];
    logic [TW-1:0]          r_dly_sel [RAM_LATENCY][LANES];

    assign w_accept = (r_state == ST_IDLE) && i_valid;
    assign w_issue  = (r_state == ST_ISSUE) ? w_grant : '0;

    ldpc_gather_round_arbiter u_arbiter (
        .i_pending (r_pending),
        .i_req     (r_req),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_valid) w_state_next = (w_in_range == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if ((r_pending & ~w_grant) == '0) w_state_next = ST_WAIT;
            ST_WAIT:  if (r_dly_valid == '0) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_accepted <= '0;
            r_error    <= 1'b0;
            for (int n = 0; n < LANES; n++) begin
                r_req[n]  <= '0;
                r_tgt[n]  <= '0;
                r_hold[n] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_pending  <= w_in_range;
                r_accepted <= w_in_range;
                if ((i_lane_valid & ~w_in_range) != '0) r_error <= 1'b1;
                for (int n = 0; n < LANES; n++) begin
                    r_req[n].branch <= i_from_branch[n*BR_W +: BR_W];
                    r_req[n].ram    <= RAM_IW'(i_ram_addr[n*RW +: RW]);
                    r_req[n].offset <= OFF_W'(i_offset[n*AW +: AW]);
                    r_tgt[n]        <= TW'(i_from_branch[n*BR_W +: BR_W]) * TW'(NUM_RAMS)
                                       + TW'(i_ram_addr[n*RW +: RW]);
                    r_hold[n]       <= '0;
                end
            end else begin
                r_pending <= r_pending & ~w_issue;
                if (r_dly_valid[RAM_LATENCY-1]) begin
                    for (int n = 0; n < LANES; n++) begin
                        if (r_dly_grant[RAM_LATENCY-1][n]) r_hold[n] <= w_cap[n*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_dly_valid <= '0;
            for (int s = 0; s < RAM_LATENCY; s++) begin
                r_dly_grant[s] <= '0;
                r_dly_sel[s]   <= '{default: '0};
            end
        end else begin
            r_dly_valid[0] <= (r_state == ST_ISSUE);
            r_dly_grant[0] <= w_issue;
            r_dly_sel[0]   <= r_tgt;
            for (int s = 1; s < RAM_LATENCY; s++) begin
                r_dly_valid[s] <= r_dly_valid[s-1];
                r_dly_grant[s] <= r_dly_grant[s-1];
                r_dly_sel[s]   <= r_dly_sel[s-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [RW-1:0] w_ram;
            assign w_ram          = i_ram_addr[gi*RW +: RW];
            assign w_in_range[gi] = i_lane_valid[gi] && (int'(w_ram) < NUM_RAMS);
            assign w_cap[gi*WIDTH +: WIDTH] =
                i_rd_data[int'(r_dly_sel[RAM_LATENCY-1][gi])*WIDTH +: WIDTH];
            assign o_data[gi*WIDTH +: WIDTH] = (o_valid && r_accepted[gi]) ? r_hold[gi] : '0;
        end

        // Each RAM port ORs in the offsets of lanes granted onto it this round.
        for (genvar gi = 0; gi < NR; gi++) begin : g_port
            logic          w_en;
            logic [AW-1:0] w_addr;
            always_comb begin
                w_en   = 1'b0;
                w_addr = '0;
                for (int n = 0; n < LANES; n++) begin
                    if (w_issue[n] && (r_tgt[n] == TW'(gi))) begin
                        w_en   = 1'b1;
                        w_addr = w_addr | AW'(r_req[n].offset);
                    end
                end
            end
            assign o_rd_en[gi]             = w_en;
            assign o_rd_addr[gi*AW +: AW]  = w_addr;
        end
    endgenerate

    assign o_ready      = (r_state == ST_IDLE);
    assign o_valid      = (r_state == ST_DONE);
    assign o_lane_valid = o_valid ? r_accepted : '0;
    assign o_error      = r_error;

endmodule

// File: tb/tb_ldpc_gather_forest.sv
// Scoreboard bench for ldpc_gather_forest: directed + random requests against a
// behavioural RAM bank and run-count latency model.
module tb_ldpc_gather_forest;

    localparam int WIDTH = 8;
    localparam int NUM_RAMS = 24;
    localparam int EXPANSION_FACTOR = 96;
    localparam int L = 2;
    localparam int AW = 7;
    localparam int RW = 5;
    localparam int NR = 8 * NUM_RAMS;
`ifdef LDPC_GATHER_OFFSET_SHARE_EN
    localparam bit SHARE = 1'b1;
`else
    localparam bit SHARE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [7:0]        i_lane_valid = '0;
    logic [8*AW-1:0]   i_offset = '0;
    logic [8*RW-1:0]   i_ram_addr = '0;
    logic [8*3-1:0]    i_from_branch = '0;
    logic [NR-1:0]     o_rd_en;
    logic [NR*AW-1:0]  o_rd_addr;
    logic [NR*WIDTH-1:0] i_rd_data;
    logic              o_valid;
    logic [7:0]        o_lane_valid;
    logic [8*WIDTH-1:0] o_data;
    logic              o_error;

    ldpc_gather_forest #(
        .WIDTH(WIDTH), .NUM_RAMS(NUM_RAMS),
        .EXPANSION_FACTOR(EXPANSION_FACTOR), .RAM_LATENCY(L)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_lane_valid(i_lane_valid), .i_offset(i_offset), .i_ram_addr(i_ram_addr),
        .i_from_branch(i_from_branch), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_data(i_rd_data), .o_valid(o_valid), .o_lane_valid(o_lane_valid),
        .o_data(o_data), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_word(input int b, input int r, input int a);
        int h;
        h = b * 197 + r * 101 + a * 3 + 11;
        h = h ^ (h >> 4) ^ (a << 2);
        return 8'(h);
    endfunction

    // RAM bank: data appears L cycles after the read enable cycle.
    logic [NR-1:0]    ram_en_pipe   [L];
    logic [NR*AW-1:0] ram_addr_pipe [L];
    always @(posedge clk) begin
        ram_en_pipe[0]   <= o_rd_en;
        ram_addr_pipe[0] <= o_rd_addr;
        for (int s = 1; s < L; s++) begin
            ram_en_pipe[s]   <= ram_en_pipe[s-1];
            ram_addr_pipe[s] <= ram_addr_pipe[s-1];
        end
    end
    always_comb begin
        i_rd_data = '0;
        for (int j = 0; j < NR; j++) begin
            if (ram_en_pipe[L-1][j] === 1'b1)
                i_rd_data[j*WIDTH +: WIDTH] = mem_word(j / NUM_RAMS, j % NUM_RAMS,
                                                       int'(ram_addr_pipe[L-1][j*AW +: AW]));
            else
                i_rd_data[j*WIDTH +: WIDTH] = 8'(j * 7 + 1) ^ 8'hC3;
        end
    end

    typedef struct {
        logic [7:0]  lv;
        logic [63:0] data;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int txn = 0;
    bit err_sticky = 1'b0;

    logic [7:0] req_lv;
    int req_br [8];
    int req_rm [8];
    int req_of [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got o_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("lane_valid", 64'(o_lane_valid), 64'(e.lv));
                chk("data", o_data, e.data);
                chk("error", 64'(o_error), 64'(e.err));
                chk("latency", 64'(cyc), 64'(e.due));
                txn++;
                $display("txn %0d: lanes=%h data=%h err=%0d cycle=%0d", txn, o_lane_valid,
                         o_data, o_error, cyc);
            end
        end
    end

    // Higher-level model: per target, rounds = number of runs of lanes that cannot share a read.
    task automatic build_expect(input int e0, output exp_t e);
        int runs [NR];
        int last_off [NR];
        int rounds;
        e.lv = '0;
        e.data = '0;
        rounds = 0;
        for (int k = 0; k < NR; k++) begin
            runs[k] = 0;
            last_off[k] = -1;
        end
        for (int n = 0; n < 8; n++) begin
            if (req_lv[n]) begin
                if (req_rm[n] < NUM_RAMS) begin
                    int k;
                    k = req_br[n] * NUM_RAMS + req_rm[n];
                    e.lv[n] = 1'b1;
                    e.data[n*8 +: 8] = mem_word(req_br[n], req_rm[n], req_of[n]);
                    if (runs[k] == 0 || !SHARE || last_off[k] != req_of[n]) runs[k]++;
                    last_off[k] = req_of[n];
                    if (runs[k] > rounds) rounds = runs[k];
                end else begin
                    err_sticky = 1'b1;
                end
            end
        end
        e.err = err_sticky;
        e.due = e0 + ((rounds == 0) ? 0 : rounds + L + 1);
    endtask

    task automatic send(input bit expect_it);
        int waited;
        exp_t e;
        waited = 0;
        while (o_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 200) begin
            errors++;
            $display("FAIL ready_timeout: got o_ready=%b expected 1 within 200 cycles", o_ready);
            return;
        end
        i_lane_valid = req_lv;
        for (int n = 0; n < 8; n++) begin
            i_from_branch[n*3 +: 3] = 3'(req_br[n]);
            i_ram_addr[n*RW +: RW]  = RW'(req_rm[n]);
            i_offset[n*AW +: AW]    = AW'(req_of[n]);
        end
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        if (expect_it) begin
            build_expect(cyc, e);
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_lane_valid", 64'(o_lane_valid), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_rd_en", 64'(|o_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(|o_rd_addr), 64'd0);
        chk("rst_error", 64'(o_error), 64'd0);
    endtask

    task automatic random_req();
        int mode;
        mode = int'($urandom_range(0, 2));
        req_lv = 8'($urandom);
        for (int n = 0; n < 8; n++) begin
            req_br[n] = (mode == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) req_rm[n] = int'($urandom_range(24, 31));
            else req_rm[n] = (mode == 2) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 23));
            req_of[n] = (mode == 2) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 95));
        end
    endtask

    initial begin
        int waited;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        check_reset_outputs();

        // Distinct branches, one round.
        req_lv = 8'hFF;
        for (int n = 0; n < 8; n++) begin req_br[n] = n; req_rm[n] = 5; req_of[n] = 10 + n; end
        send(1'b1);
        // All lanes on one RAM: eight rounds.
        for (int n = 0; n < 8; n++) begin req_br[n] = 3; req_rm[n] = 0; req_of[n] = n; end
        send(1'b1);
        // Two lanes, identical address.
        req_lv = 8'h03;
        for (int n = 0; n < 8; n++) begin req_br[n] = 2; req_rm[n] = 4; req_of[n] = 9; end
        send(1'b1);
        // Out-of-range RAM index on lane 6.
        req_lv = 8'hFF;
        for (int n = 0; n < 8; n++) begin req_br[n] = n; req_rm[n] = (n == 6) ? 30 : n; req_of[n] = n * 3; end
        send(1'b1);
        // Empty request.
        req_lv = 8'h00;
        send(1'b1);

        for (int t = 0; t < 30; t++) begin
            random_req();
            send(1'b1);
        end

        // Reset while waiting for read data.
        waited = 0;
        while (o_ready !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
        req_lv = 8'hFF;
        for (int n = 0; n < 8; n++) begin req_br[n] = n; req_rm[n] = 5; req_of[n] = 10 + n; end
        send(1'b0);
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        err_sticky = 1'b0;
        check_reset_outputs();
        repeat (8) @(negedge clk);

        for (int t = 0; t < 10; t++) begin
            random_req();
            send(1'b1);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 300) begin @(negedge clk); waited++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding results expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
